// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory bus bridge.
package dmem_pkg;

    localparam int          TIMEOUT_DEFAULT  = 255;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_DONE = 2'd3
    } dmem_state_e;

    // Wide enough for any supported data width; callers cast to their own width.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts request cycles without an acknowledge and flags the cycle whose
// increment would bring the count up to the limit.
module bus_timeout_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       count_en,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // Flagging one cycle early lets the request drop on the same edge the count hits the limit.
    assign expired = count_en && (count == limit - 8'd1);

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the CPU memory stage onto a req/ack data bus, with a one-entry
// posted write buffer and a bus timeout.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemStallM,
    output logic              BusErrM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    dmem_state_e state;
    dmem_state_e next_state;

    logic wbuf_valid;
    logic start_write;
    logic start_read;
    logic ack_seen;
    logic count_en;
    logic expired;
    logic bus_done;

    assign ack_seen = bus_req && bus_ack;
    assign count_en = bus_req && !bus_ack;
    assign bus_done = ack_seen || expired;

    bus_timeout_ctr u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_write || start_read),
        .count_en (count_en),
        .limit    (8'(TIMEOUT)),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_write = 1'b0;
        start_read  = 1'b0;
        case (state)
            IDLE: begin
                if (MemWriteM && !wbuf_valid) begin
                    start_write = 1'b1;
                    next_state  = WRITE;
                end else if (MemReadM && !wbuf_valid) begin
                    start_read = 1'b1;
                    next_state = READ_WAIT;
                end
            end
            WRITE: begin
                if (bus_done) begin
                    next_state = IDLE;
                end
            end
            READ_WAIT: begin
                if (bus_done) begin
                    next_state = READ_DONE;
                end
            end
            READ_DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The bus registers double as the write buffer storage; wbuf_valid marks them as owed to the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbuf_valid <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            ReadDataM  <= '0;
            BusErrM    <= 1'b0;
        end else begin
            BusErrM <= expired;
            if (start_write || start_read) begin
                bus_req  <= 1'b1;
                bus_we   <= start_write;
                bus_addr <= DATA_W'(word_align(64'(ALUResultM)));
                if (start_write) begin
                    bus_wdata <= WriteDataM;
                end
            end else if (bus_done) begin
                bus_req <= 1'b0;
            end
            if (start_write) begin
                wbuf_valid <= 1'b1;
            end else if (state == WRITE && bus_done) begin
                wbuf_valid <= 1'b0;
            end
            if (state == READ_WAIT) begin
                if (ack_seen) begin
                    ReadDataM <= bus_rdata;
                end else if (expired) begin
                    ReadDataM <= ERR_DATA;
                end
            end
        end
    end

    // Gated by reset so the CPU is never held while the bridge is being cleared.
    assign MemStallM = rst && ((MemReadM && state != READ_DONE) || (MemWriteM && wbuf_valid));

endmodule
